// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: size encodings, FSM state enum, byte-enable constants, alignment helpers.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;   // 2'b11 is also handled as a word

    localparam logic [3:0] BE_BYTE    = 4'b0001;  // shifted left by the byte offset
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Half with odd address, or word with any nonzero low bits.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        if (size == MEM_BYTE) return 1'b0;
        if (size == MEM_HALF) return lo[0];
        return lo != 2'b00;
    endfunction

    // Force the low address bits onto the natural boundary of the access size.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        if (size == MEM_BYTE) return lo;
        if (size == MEM_HALF) return {lo[1], 1'b0};
        return 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Latency: n/a (wires only).
// Backpressure: req is held until a single-cycle ack pulse completes the transfer.
// Signals: dmem_req/we/addr/wdata/be from master; dmem_rdata/ack from slave.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication, byte enables, load extraction and extension.
// Latency: combinational.
// Backpressure: none.
// Ports: size/is_unsigned/addr_lo select the lanes; wd -> wdata/be; rdata -> rdata_ext.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte     = rdata[{addr_lo, 3'b000} +: 8];
        rhalf     = rdata[{addr_lo[1], 4'b0000} +: 16];
        wdata     = wd;
        be        = BE_WORD;
        rdata_ext = rdata;
        case (size)
            MEM_BYTE: begin
                wdata     = {4{wd[7:0]}};
                be        = BE_BYTE << addr_lo;
                rdata_ext = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            MEM_HALF: begin
                wdata     = {2{wd[15:0]}};
                be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                rdata_ext = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                wdata     = wd;
                be        = BE_WORD;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: turns an EX/MEM load/store into one req/ack bus transfer.
// Latency: 3 cycles minimum (IDLE, WAIT, DONE); stall_m high in IDLE-with-op and all WAIT cycles.
// Backpressure: waits for dmem_ack indefinitely unless TIMEOUT_CYCLES != 0, then ends with bus_err_m.
// Ports: clk, rst_n; pipeline side mem_*_m / alu_result_m / write_data_m in,
//        read_data_m / stall_m / bus_err_m / misalign_m out; dmem bus via mem_access_stage_if.master.
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and report misalign_m;
// otherwise the low address bits are silently aligned and misalign_m stays 0.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [1:0]        mem_size_m,
    input  logic              mem_unsigned_m,
    input  logic [ADDR_W-1:0] alu_result_m,
    input  logic [31:0]       write_data_m,
    output logic [31:0]       read_data_m,
    output logic              stall_m,
    output logic              bus_err_m,
    output logic              misalign_m,
    mem_access_stage_if.master dmem
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lo_q;

    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       rd_q;
    logic              err_q, mis_q;

    logic              op, trap, timeout_hit;
    logic [1:0]        lane_size, lane_lo;
    logic              lane_uns;
    logic [31:0]       lane_wdata, lane_rdata;
    logic [3:0]        lane_be;

    assign op = mem_read_m | mem_write_m;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(mem_size_m, alu_result_m[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // In IDLE the lanes are computed from the live request (store data, byte enables);
    // in WAIT from the latched request, so the load is extracted with the issuing op's size.
    always_comb begin
        if (state_q == ST_IDLE) begin
            lane_size = mem_size_m;
            lane_uns  = mem_unsigned_m;
            lane_lo   = align_lo(mem_size_m, alu_result_m[1:0]);
        end else begin
            lane_size = size_q;
            lane_uns  = uns_q;
            lane_lo   = lo_q;
        end
    end

    mem_lane_align u_lane (
        .size        (lane_size),
        .is_unsigned (lane_uns),
        .addr_lo     (lane_lo),
        .wd          (write_data_m),
        .rdata       (dmem.dmem_rdata),
        .wdata       (lane_wdata),
        .be          (lane_be),
        .rdata_ext   (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall_m = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    stall_m = 1'b1;
                    state_d = trap ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_m = 1'b1;
                if (dmem.dmem_ack || timeout_hit) state_d = ST_DONE;
            end
            // The op is still presented during DONE; going straight to IDLE keeps it from reissuing.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            size_q  <= MEM_BYTE;
            uns_q   <= 1'b0;
            lo_q    <= 2'b00;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op) begin
                        if (trap) begin
                            mis_q <= 1'b1;
                            rd_q  <= '0;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= ~mem_read_m;   // load wins if both are asserted
                            addr_q  <= {alu_result_m[ADDR_W-1:2], 2'b00};
                            wdata_q <= lane_wdata;
                            be_q    <= lane_be;
                            size_q  <= mem_size_m;
                            uns_q   <= mem_unsigned_m;
                            lo_q    <= lane_lo;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (dmem.dmem_ack) begin
                        req_q <= 1'b0;
                        rd_q  <= we_q ? 32'b0 : lane_rdata;
                    end else if (timeout_hit) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        rd_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                    mis_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign read_data_m     = rd_q;
    assign bus_err_m       = err_q;
    assign misalign_m      = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of load/store transactions plus a reset-in-WAIT sequence.
// Latency: n/a.
// Backpressure: the bench plays the memory and chooses the ack cycle per vector.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_m, mem_write_m, mem_unsigned_m;
    logic [1:0]  mem_size_m;
    logic [31:0] alu_result_m, write_data_m;
    logic [31:0] read_data_m;
    logic        stall_m, bus_err_m, misalign_m;

    int checks = 0;
    int failures = 0;

    mem_access_stage_if #(.ADDR_W(32)) bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read_m     (mem_read_m),
        .mem_write_m    (mem_write_m),
        .mem_size_m     (mem_size_m),
        .mem_unsigned_m (mem_unsigned_m),
        .alu_result_m   (alu_result_m),
        .write_data_m   (write_data_m),
        .read_data_m    (read_data_m),
        .stall_m        (stall_m),
        .bus_err_m      (bus_err_m),
        .misalign_m     (misalign_m),
        .dmem           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ack_dly;   // WAIT-cycle index carrying the ack; -1 = never
        logic [31:0] rdata;
        logic        chk_bus;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_mis;
        int          e_stall;
        int          e_req;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          stall_n = 0;
        int          req_n   = 0;
        int          widx    = 0;
        int          cyc     = 0;
        logic        seen    = 1'b0;
        logic [31:0] c_addr  = '0;
        logic [31:0] c_wdata = '0;
        logic [3:0]  c_be    = '0;
        logic        c_we    = 1'b0;
        mem_read_m     = v.rd;
        mem_write_m    = v.wr;
        mem_size_m     = v.size;
        mem_unsigned_m = v.uns;
        alu_result_m   = v.addr;
        write_data_m   = v.wd;
        #1;
        while (cyc < 40 && stall_m) begin
            stall_n++;
            if (bus.dmem_req) begin
                req_n++;
                if (!seen) begin
                    seen    = 1'b1;
                    c_addr  = bus.dmem_addr;
                    c_wdata = bus.dmem_wdata;
                    c_be    = bus.dmem_be;
                    c_we    = bus.dmem_we;
                end
                if (widx == v.ack_dly) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = v.rdata;
                end
                widx++;
            end
            @(posedge clk);
            #1;
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = 32'h0BAD_0BAD;
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 40) begin
            failures++;
            checks++;
            $display("FAIL %s done_budget: stall still high after %0d cycles, required DONE", v.name, cyc);
        end
        // Now in DONE.
        chk({v.name, " stall_cycles"}, stall_n, v.e_stall);
        chk({v.name, " req_cycles"}, req_n, v.e_req);
        if (v.chk_bus) begin
            chk({v.name, " dmem_addr"}, c_addr, v.e_addr);
            chk({v.name, " dmem_be"}, {28'b0, c_be}, {28'b0, v.e_be});
            chk({v.name, " dmem_wdata"}, c_wdata, v.e_wdata);
            chk({v.name, " dmem_we"}, {31'b0, c_we}, {31'b0, v.e_we});
        end
        chk({v.name, " read_data_m"}, read_data_m, v.e_rd);
        chk({v.name, " bus_err_m"}, {31'b0, bus_err_m}, {31'b0, v.e_err});
        chk({v.name, " misalign_m"}, {31'b0, misalign_m}, {31'b0, v.e_mis});
        chk({v.name, " done_req"}, {31'b0, bus.dmem_req}, 32'h0);
        // Op stays asserted through DONE; next cycle must be a clean IDLE.
        @(posedge clk);
        #1;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        #1;
        chk({v.name, " idle_stall"}, {31'b0, stall_m}, 32'h0);
        chk({v.name, " idle_err"}, {31'b0, bus_err_m}, 32'h0);
        chk({v.name, " idle_mis"}, {31'b0, misalign_m}, 32'h0);
        chk({v.name, " idle_req"}, {31'b0, bus.dmem_req}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        //            name          rd wr size  un addr        wd            dly rdata         bus e_addr     be    e_wdata       we e_rd          err mis stall req
        vecs[0]  = '{"sw_word",    0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 1, 32'h0,        1, 32'h100, 4'hF, 32'hDEADBEEF, 1, 32'h0,        0, 0, 3, 2};
        vecs[1]  = '{"lb_signed",  1, 0, 2'b00, 0, 32'h103, 32'h0,        0, 32'h80112233, 1, 32'h100, 4'h8, 32'h0,        0, 32'hFFFFFF80, 0, 0, 2, 1};
        vecs[2]  = '{"lbu",        1, 0, 2'b00, 1, 32'h103, 32'h0,        0, 32'h80112233, 1, 32'h100, 4'h8, 32'h0,        0, 32'h00000080, 0, 0, 2, 1};
        vecs[3]  = '{"lh_signed",  1, 0, 2'b01, 0, 32'h102, 32'h0,        0, 32'h80017FFF, 1, 32'h100, 4'hC, 32'h0,        0, 32'hFFFF8001, 0, 0, 2, 1};
        vecs[4]  = '{"sh_hi",      0, 1, 2'b01, 0, 32'h102, 32'h1234,     0, 32'h0,        1, 32'h100, 4'hC, 32'h12341234, 1, 32'h0,        0, 0, 2, 1};
        vecs[5]  = '{"timeout",    1, 0, 2'b10, 0, 32'h200, 32'h0,       -1, 32'hFFFFFFFF, 1, 32'h200, 4'hF, 32'h0,        0, 32'h0,        1, 0, 5, 4};
        vecs[6]  = '{"ack_vs_to",  1, 0, 2'b10, 0, 32'h300, 32'h0,        3, 32'h55AA55AA, 1, 32'h300, 4'hF, 32'h0,        0, 32'h55AA55AA, 0, 0, 5, 4};
        vecs[7]  = '{"sb_lane1",   0, 1, 2'b00, 0, 32'h101, 32'hAB,       2, 32'h0,        1, 32'h100, 4'h2, 32'hABABABAB, 1, 32'h0,        0, 0, 4, 3};
        vecs[8]  = '{"lh_lo",      1, 0, 2'b01, 0, 32'h100, 32'h0,        0, 32'h1234F00D, 1, 32'h100, 4'h3, 32'h0,        0, 32'hFFFFF00D, 0, 0, 2, 1};
        vecs[9]  = '{"lbu_lane1",  1, 0, 2'b00, 1, 32'h101, 32'h0,        0, 32'h1234F00D, 1, 32'h100, 4'h2, 32'h0,        0, 32'h000000F0, 0, 0, 2, 1};
        vecs[10] = '{"rd_wr_both", 1, 1, 2'b10, 0, 32'h10,  32'h11111111, 0, 32'h22222222, 1, 32'h10,  4'hF, 32'h11111111, 0, 32'h22222222, 0, 0, 2, 1};
        vecs[11] = '{"size11",     1, 0, 2'b11, 0, 32'h20,  32'h0,        0, 32'h87654321, 1, 32'h20,  4'hF, 32'h0,        0, 32'h87654321, 0, 0, 2, 1};
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[12] = '{"lw_mis",     1, 0, 2'b10, 0, 32'h101, 32'h0,        0, 32'hCAFEF00D, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        0, 1, 1, 0};
        vecs[13] = '{"lhu_mis",    1, 0, 2'b01, 1, 32'h103, 32'h0,        0, 32'h80017FFF, 0, 32'h0,   4'h0, 32'h0,        0, 32'h0,        0, 1, 1, 0};
`else
        vecs[12] = '{"lw_mis",     1, 0, 2'b10, 0, 32'h101, 32'h0,        0, 32'hCAFEF00D, 1, 32'h100, 4'hF, 32'h0,        0, 32'hCAFEF00D, 0, 0, 2, 1};
        vecs[13] = '{"lhu_mis",    1, 0, 2'b01, 1, 32'h103, 32'h0,        0, 32'h80017FFF, 1, 32'h100, 4'hC, 32'h0,        0, 32'h00008001, 0, 0, 2, 1};
`endif

        rst_n          = 1'b0;
        mem_read_m     = 1'b0;
        mem_write_m    = 1'b0;
        mem_size_m     = 2'b00;
        mem_unsigned_m = 1'b0;
        alu_result_m   = '0;
        write_data_m   = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        #2;
        chk("rst dmem_req", {31'b0, bus.dmem_req}, 32'h0);
        chk("rst dmem_we", {31'b0, bus.dmem_we}, 32'h0);
        chk("rst dmem_be", {28'b0, bus.dmem_be}, 32'h0);
        chk("rst dmem_addr", bus.dmem_addr, 32'h0);
        chk("rst dmem_wdata", bus.dmem_wdata, 32'h0);
        chk("rst read_data_m", read_data_m, 32'h0);
        chk("rst bus_err_m", {31'b0, bus_err_m}, 32'h0);
        chk("rst misalign_m", {31'b0, misalign_m}, 32'h0);
        chk("rst stall_m", {31'b0, stall_m}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset while a load is outstanding, then a stray ack afterwards.
        #1;
        mem_read_m   = 1'b1;
        mem_size_m   = 2'b10;
        alu_result_m = 32'h40;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rstwait req_before", {31'b0, bus.dmem_req}, 32'h1);
        chk("rstwait stall_before", {31'b0, stall_m}, 32'h1);
        rst_n      = 1'b0;
        mem_read_m = 1'b0;
        #1;
        chk("rstwait req_async", {31'b0, bus.dmem_req}, 32'h0);
        chk("rstwait stall_async", {31'b0, stall_m}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rstwait late_req", {31'b0, bus.dmem_req}, 32'h0);
            chk("rstwait late_stall", {31'b0, stall_m}, 32'h0);
            chk("rstwait late_rd", read_data_m, 32'h0);
            chk("rstwait late_err", {31'b0, bus_err_m}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline; sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns the load/store request latched in EX/MEM into a data-memory bus transaction using a req/ack handshake.
- Stalls the pipeline while the transaction is outstanding, then presents sign- or zero-extended load data (read_data_m) for capture into MEM/WB.
- Ends any transaction that never completes with a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: cycles spent in WAIT without ack before a bus error is declared; 0 disables the timeout.
- ADDR_W, 32: address width. dmem_addr is always word-aligned.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read_m  in  1  load request from EX/MEM.
- mem_write_m  in  1  store request from EX/MEM. Never high together with mem_read_m; if both are high, the load wins.
- mem_size_m  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned_m  in  1  1 = zero-extend loads, 0 = sign-extend.
- alu_result_m  in  ADDR_W  effective byte address.
- write_data_m  in  32  store data, right-justified.
- read_data_m  out  32  extended load result, registered; valid in DONE.
- stall_m  out  1  hold IF/ID/EX and EX/MEM this cycle.
- bus_err_m  out  1  timeout occurred; valid in DONE.
- misalign_m  out  1  misaligned access; valid in DONE. Tied to 0 without the optional feature.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables, little-endian.
- dmem_rdata  in  32  read word; sampled in the cycle dmem_ack is high.
- dmem_ack  in  1  transaction complete; single-cycle pulse.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE, counter = 0.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, read_data_m, bus_err_m and misalign_m all = 0.
  - A reset during WAIT drops dmem_req at once. Any later ack is ignored because the state is IDLE with no op.
- FSM states: IDLE, WAIT, DONE.
- IDLE, op = mem_read_m | mem_write_m:
  - op = 0: stay in IDLE, stall_m = 0.
  - op = 1: stall_m = 1 (combinational). On the next edge, register the address, we, be and wdata; set dmem_req = 1; go to WAIT with counter = 0.
- WAIT:
  - stall_m = 1. dmem_req and all dmem_* outputs are held stable.
  - dmem_ack = 1: capture the extracted dmem_rdata into read_data_m (loads only; stores write 0), drop dmem_req, go to DONE.
  - Otherwise counter increments. If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with no ack: drop dmem_req, bus_err_m = 1, read_data_m = 0, go to DONE.
  - An ack and the timeout in the same cycle: the ack wins.
- DONE:
  - stall_m = 0, so MEM/WB captures read_data_m at the end of this cycle.
  - Unconditionally return to IDLE. The same op is still on the inputs during DONE and must not restart.
  - bus_err_m and misalign_m clear on the DONE→IDLE edge.
- Minimum occupancy with a zero-wait memory (ack in the first WAIT cycle) is 3 cycles; stall_m is high for 2 of them.
- Store lanes:
  - Byte: wdata = {4{wd[7:0]}}, be = 4'b0001 << addr[1:0].
  - Half: wdata = {2{wd[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata = wd, be = 1111.
- Loads: dmem_be follows the same lane rules. Select the byte or half by addr[1:0] / addr[1], then sign- or zero-extend per mem_unsigned_m.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN. An access is misaligned when it is a half with addr[0] = 1, or a word (size 10 or 11) with addr[1:0] != 0.
- Defined: a misaligned op in IDLE issues no bus transaction. On the next edge go straight to DONE with misalign_m = 1 and read_data_m = 0; stall_m is high for 1 cycle.
- Undefined: the low address bits are forced to alignment before lane selection (half: addr[0] = 0; word: addr[1:0] = 0). misalign_m is constant 0.

Decomposition:
- Package mem_pkg:
  - size encodings MEM_BYTE, MEM_HALF, MEM_WORD.
  - state enum for IDLE/WAIT/DONE.
  - byte-enable constants.
- Sub-module mem_lane_align (purely combinational): store lane replication, be generation, load extraction and extension. Instantiated once in mem_access_stage.

Test Plan:
- Store word, addr 0x100, data 0xDEADBEEF, ack after 2 wait cycles → dmem_addr = 0x100, be = 1111, wdata = 0xDEADBEEF; stall_m high for 3 cycles, then DONE.
- Signed byte load, addr 0x103, dmem_rdata = 0x80112233 → read_data_m = 0xFFFFFF80. Unsigned → 0x00000080. be = 1000.
- Half load, addr 0x102, rdata 0x8001_7FFF, signed → read_data_m = 0xFFFF8001; half store, addr 0x102, data 0x1234 → be = 1100, wdata = 0x12341234.
- No ack, TIMEOUT_CYCLES = 4 → dmem_req drops after 4 WAIT cycles, bus_err_m = 1 in DONE, read_data_m = 0.
- rst_n pulsed low during WAIT, then an ack arrives afterwards → dmem_req = 0 immediately, state IDLE, ack ignored, no stall.
- With MEM_MISALIGN_TRAP_EN, word load at 0x101 → no dmem_req, misalign_m = 1 in DONE, stall_m high for 1 cycle. Without the macro → dmem_addr = 0x100, be = 1111, misalign_m = 0.
